// File: rtl/imem_loader.sv
// Boot loader: byte stream -> 32-bit instruction-memory writes, core held in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, LAST, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] len_q, len_d;
    logic [23:0] buf_q, buf_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        xfer;
    logic [15:0] new_len;

    assign xfer    = in_valid && in_ready_q;
    assign new_len = {in_data, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        buf_d      = buf_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = LEN0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d  = 8'h00;
`endif
            end
            LEN0: if (xfer) begin
                len_d   = {8'h00, in_data};
                state_d = LEN1;
            end
            LEN1: if (xfer) begin
                len_d = new_len;
                if (new_len == 16'd0 || {1'b0, new_len} > DEPTH_W)
                    state_d = ERR;
                else
                    state_d = DATA;
            end
            DATA: if (xfer) begin
                byte_idx_d = byte_idx_q + 2'd1;
                unique case (byte_idx_q)
                    2'd0: buf_d[7:0]   = in_data;
                    2'd1: buf_d[15:8]  = in_data;
                    2'd2: buf_d[23:16] = in_data;
                    2'd3: begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {in_data, buf_q};
                        wr_addr_d = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        if (word_idx_q == len_q - 16'd1)
                            state_d = LAST;
                        else
                            word_idx_d = word_idx_q + 16'd1;
                    end
                endcase
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LAST: state_d = CSUM;
            CSUM: if (xfer) begin
                state_d = (in_data == csum_q) ? DONE : ERR;
            end
`else
            LAST: state_d = DONE;
`endif
            default: state_d = state_q;
        endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
        // every byte before the checksum byte itself folds into the XOR
        if (xfer && (state_q inside {LEN0, LEN1, DATA}))
            csum_d = csum_q ^ in_data;
`endif
        in_ready_d = state_d inside {LEN0, LEN1, DATA, CSUM};
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERR);
        core_rst_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            len_q      <= 16'd0;
            buf_q      <= 24'd0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 32'd0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign core_rst = core_rst_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed vector table, timing sequences, random streams vs model.
// Works with IMEM_LOADER_CHECKSUM_EN defined or undefined.
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_rst;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int xfers = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(posedge clk) if (in_valid && in_ready) xfers++;
    always @(negedge clk) if (wr_en) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wa_q.delete();
        wd_q.delete();
        xfers = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    // Reference model: derived from stream format rules only
    logic [31:0] ex_addr[$];
    logic [31:0] ex_data[$];
    int ex_acc;
    bit ex_done, ex_err;

    task automatic model(input logic [7:0] s[$]);
        int n;
        logic [7:0] x;
        ex_addr.delete();
        ex_data.delete();
        n = {s[1], s[0]};
        if (n == 0 || n > DEPTH) begin
            ex_acc = 2;
            ex_done = 0;
            ex_err = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            ex_addr.push_back(BASE + 32'(4 * i));
            ex_data.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
        end
        ex_acc = 2 + 4 * n;
        ex_done = 1;
        ex_err = 0;
        if (CS == 1) begin
            x = 8'h00;
            for (int i = 0; i < ex_acc; i++) x ^= s[i];
            ex_done = (s[ex_acc] == x);
            ex_err = !ex_done;
            ex_acc++;
        end
    endtask

    task automatic final_checks(input string tag, input int acc, input int nwr,
                                input bit edone, input bit eerr);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_nwr"}, wa_q.size(), nwr);
        chk({tag, "_done"}, 32'(done), 32'(edone));
        chk({tag, "_error"}, 32'(error), 32'(eerr));
        chk({tag, "_core_rst"}, 32'(core_rst), 32'(!edone));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_xfers"}, xfers, acc);
        in_valid = 1'b1;
        in_data = 8'($urandom);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_no_accept_after"}, xfers, acc);
    endtask

    typedef struct {
        logic [95:0] b;
        int          len;
        bit          gaps;
        int          n_wr;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          edone;
        bit          eerr;
    } vec_t;

    vec_t vecs[5];
    int nv;

    initial begin
        logic [7:0] s[$];
        int n, pick;
        logic [7:0] x;

        nv = 0;
        vecs[nv++] = '{96'h02_00_13_00_00_00_93_00_A0_00_22_00, 10 + CS, 1'b0, 2,
                       32'h0000_0013, 32'h00A0_0093, 1'b1, 1'b0};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[nv++] = '{96'h02_00_13_00_00_00_93_00_A0_00_23_00, 11, 1'b0, 2,
                       32'h0000_0013, 32'h00A0_0093, 1'b0, 1'b1};
`endif
        vecs[nv++] = '{96'h00_00_00_00_00_00_00_00_00_00_00_00, 2, 1'b0, 0,
                       32'h0, 32'h0, 1'b0, 1'b1};
        vecs[nv++] = '{96'h01_01_00_00_00_00_00_00_00_00_00_00, 2, 1'b0, 0,
                       32'h0, 32'h0, 1'b0, 1'b1};
        vecs[nv++] = '{96'h02_00_13_00_00_00_93_00_A0_00_22_00, 10 + CS, 1'b1, 2,
                       32'h0000_0013, 32'h00A0_0093, 1'b1, 1'b0};

        // reset values
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        for (int v = 0; v < nv; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].len; i++)
                send_byte(vecs[v].b[95-8*i -: 8],
                          vecs[v].gaps ? int'($urandom_range(1, 3)) : 0);
            final_checks($sformatf("vec%0d", v), vecs[v].len, vecs[v].n_wr,
                         vecs[v].edone, vecs[v].eerr);
            if (vecs[v].n_wr > 0 && wa_q.size() >= 2) begin
                chk($sformatf("vec%0d_a0", v), wa_q[0], BASE);
                chk($sformatf("vec%0d_d0", v), wd_q[0], vecs[v].d0);
                chk($sformatf("vec%0d_a1", v), wa_q[1], BASE + 32'd4);
                chk($sformatf("vec%0d_d1", v), wd_q[1], vecs[v].d1);
            end
        end

        // completion timing with in_valid held high
        do_reset();
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        foreach (s[i]) send_byte(s[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t_last_wr_en", 32'(wr_en), 32'd1);
        chk("t_last_core_rst", 32'(core_rst), 32'd1);
        chk("t_last_in_ready", 32'(in_ready), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h22, 0);
        @(negedge clk);
        in_valid = 1'b0;
`else
        @(negedge clk);
`endif
        chk("t_done_wr_en", 32'(wr_en), 32'd0);
        chk("t_done_done", 32'(done), 32'd1);
        chk("t_done_core_rst", 32'(core_rst), 32'd0);

        // length rejection timing
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t_len0_error", 32'(error), 32'd1);
        chk("t_len0_in_ready", 32'(in_ready), 32'd0);

        // reset mid-load, then a full reload
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(vecs[0].b[95-8*i -: 8], 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_wr_en", 32'(wr_en), 32'd0);
        chk("mid_wr_addr", wr_addr, BASE);
        chk("mid_wr_data", wr_data, 32'd0);
        chk("mid_core_rst", 32'(core_rst), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_error", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wa_q.delete();
        wd_q.delete();
        xfers = 0;
        for (int i = 0; i < vecs[0].len; i++) send_byte(vecs[0].b[95-8*i -: 8], 0);
        final_checks("reload", vecs[0].len, 2, 1'b1, 1'b0);

        // random streams against the model
        for (int it = 0; it < 40; it++) begin
            s.delete();
            pick = $urandom_range(0, 9);
            if (pick == 0) n = 0;
            else if (pick == 1) n = DEPTH + 1 + int'($urandom_range(0, 300));
            else n = $urandom_range(1, 5);
            s.push_back(n[7:0]);
            s.push_back(n[15:8]);
            if (n > 0 && n <= DEPTH) begin
                for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
                if (CS == 1) begin
                    x = 8'h00;
                    foreach (s[i]) x ^= s[i];
                    if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                    s.push_back(x);
                end
            end
            model(s);
            do_reset();
            for (int i = 0; i < ex_acc; i++) send_byte(s[i], $urandom_range(0, 3));
            final_checks($sformatf("rnd%0d", it), ex_acc, ex_addr.size(), ex_done, ex_err);
            for (int i = 0; i < ex_addr.size() && i < wa_q.size(); i++) begin
                chk($sformatf("rnd%0d_addr%0d", it, i), wa_q[i], ex_addr[i]);
                chk($sformatf("rnd%0d_data%0d", it, i), wd_q[i], ex_data[i]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
